// File: rtl/orion_types.sv
// Shared core types: datapath widths plus writeback arbiter defaults and FIFO entry layout.
package orion_types;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned RF_IDX_BITS     = 5;

    localparam int unsigned WB_FIFO_DEPTH   = 2;
    localparam int unsigned WB_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [RF_IDX_BITS-1:0] rd_s;
        logic [XLEN-1:0]        rd_v;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Multi-cycle result queue for the writeback arbiter; power-of-two depth, one push and one pop
// per cycle.
module wb_fifo
    import orion_types::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WB_ENTRY_W-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [WB_ENTRY_W-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Extra MSB on each pointer distinguishes full from empty after wrap-around.
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [WB_ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the in-order pipeline and a queued multi-cycle unit.
// Define WB_STARVE_GUARD_EN to add the starvation counter that forces FIFO drains.
module wb_arbiter
    import orion_types::*;
#(
    parameter int unsigned DEPTH        = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pipe_valid_i,
    input  logic                   pipe_we_i,
    input  logic [RF_IDX_BITS-1:0] pipe_rd_s_i,
    input  logic [XLEN-1:0]        pipe_rd_v_i,
    input  logic                   mc_valid_i,
    output logic                   mc_ready_o,
    input  logic [RF_IDX_BITS-1:0] mc_rd_s_i,
    input  logic [XLEN-1:0]        mc_rd_v_i,
    output logic                   stall_o,
    output logic                   we_o,
    output logic [RF_IDX_BITS-1:0] rd_s_o,
    output logic [XLEN-1:0]        rd_v_o
);

    logic                   pipe_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   force_drain;
    logic [WB_ENTRY_W-1:0]  head_bits;
    wb_entry_t              head;
    wb_entry_t              push_entry;

    logic                   win;
    logic [RF_IDX_BITS-1:0] win_s;
    logic [XLEN-1:0]        win_v;

    logic                   we_q;
    logic [RF_IDX_BITS-1:0] rd_s_q;
    logic [XLEN-1:0]        rd_v_q;

    assign pipe_req   = pipe_valid_i && pipe_we_i && (pipe_rd_s_i != '0);
    assign mc_ready_o = !fifo_full;
    // x0 writes complete the handshake but never occupy a slot.
    assign fifo_push  = mc_valid_i && !fifo_full && (mc_rd_s_i != '0);
    assign push_entry = '{rd_s: mc_rd_s_i, rd_v: mc_rd_v_i};
    assign head       = wb_entry_t'(head_bits);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve_q <= '0;
        end else if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign force_drain = !fifo_empty && (starve_q == CW'(STARVE_LIMIT));
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_drain         = 1'b0;
`endif

    assign stall_o = force_drain;

    always_comb begin
        win      = 1'b0;
        win_s    = '0;
        win_v    = '0;
        fifo_pop = 1'b0;
        if (force_drain) begin
            win      = 1'b1;
            win_s    = head.rd_s;
            win_v    = head.rd_v;
            fifo_pop = 1'b1;
        end else if (pipe_req) begin
            win   = 1'b1;
            win_s = pipe_rd_s_i;
            win_v = pipe_rd_v_i;
        end else if (!fifo_empty) begin
            win      = 1'b1;
            win_s    = head.rd_s;
            win_v    = head.rd_v;
            fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            rd_s_q <= '0;
            rd_v_q <= '0;
        end else begin
            we_q <= win;
            if (win) begin
                rd_s_q <= win_s;
                rd_v_q <= win_v;
            end
        end
    end

    assign we_o   = we_q;
    assign rd_s_o = rd_s_q;
    assign rd_v_o = rd_v_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: pipe writes, FIFO drain, x0 drop, fill/starvation,
// push/pop wrap ordering and mid-operation reset.
module tb_wb_arbiter;
    import orion_types::*;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   pipe_valid_i;
    logic                   pipe_we_i;
    logic [RF_IDX_BITS-1:0] pipe_rd_s_i;
    logic [XLEN-1:0]        pipe_rd_v_i;
    logic                   mc_valid_i;
    logic                   mc_ready_o;
    logic [RF_IDX_BITS-1:0] mc_rd_s_i;
    logic [XLEN-1:0]        mc_rd_v_i;
    logic                   stall_o;
    logic                   we_o;
    logic [RF_IDX_BITS-1:0] rd_s_o;
    logic [XLEN-1:0]        rd_v_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    wb_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pipe_valid_i (pipe_valid_i),
        .pipe_we_i    (pipe_we_i),
        .pipe_rd_s_i  (pipe_rd_s_i),
        .pipe_rd_v_i  (pipe_rd_v_i),
        .mc_valid_i   (mc_valid_i),
        .mc_ready_o   (mc_ready_o),
        .mc_rd_s_i    (mc_rd_s_i),
        .mc_rd_v_i    (mc_rd_v_i),
        .stall_o      (stall_o),
        .we_o         (we_o),
        .rd_s_o       (rd_s_o),
        .rd_v_o       (rd_v_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pipe_off();
        pipe_valid_i = 1'b0;
        pipe_we_i    = 1'b0;
        pipe_rd_s_i  = '0;
        pipe_rd_v_i  = '0;
    endtask

    task automatic mc_off();
        mc_valid_i = 1'b0;
        mc_rd_s_i  = '0;
        mc_rd_v_i  = '0;
    endtask

    task automatic pipe_on(input logic [RF_IDX_BITS-1:0] rd, input logic [XLEN-1:0] v);
        pipe_valid_i = 1'b1;
        pipe_we_i    = 1'b1;
        pipe_rd_s_i  = rd;
        pipe_rd_v_i  = v;
    endtask

    task automatic mc_on(input logic [RF_IDX_BITS-1:0] rd, input logic [XLEN-1:0] v);
        mc_valid_i = 1'b1;
        mc_rd_s_i  = rd;
        mc_rd_v_i  = v;
    endtask

    initial begin
        rst_i = 1'b1;
        pipe_off();
        mc_off();
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_we", we_o, 0);
        check("rst_rd_s", rd_s_o, 0);
        check("rst_rd_v", rd_v_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_ready", mc_ready_o, 1);

        // Pipeline write rd=5 val=0xA5, one cycle latency
        pipe_on(5, 32'hA5);
        tick();
        pipe_off();
        check("pipe_we", we_o, 1);
        check("pipe_rd_s", rd_s_o, 5);
        check("pipe_rd_v", rd_v_o, 32'hA5);
        tick();
        check("idle_we", we_o, 0);
        check("idle_hold_s", rd_s_o, 5);
        check("idle_hold_v", rd_v_o, 32'hA5);

        // Non-writing and x0 pipeline results never write
        pipe_on(7, 32'h77);
        pipe_we_i = 1'b0;
        tick();
        check("pipe_nowe", we_o, 0);
        pipe_on(0, 32'h11);
        tick();
        pipe_off();
        check("pipe_x0", we_o, 0);
        check("pipe_x0_hold", rd_v_o, 32'hA5);

        // mc push rd=3 val=7: no bypass, written after the following edge
        mc_on(3, 7);
        tick();
        mc_off();
        check("mc_nobypass", we_o, 0);
        check("mc_ready_occ1", mc_ready_o, 1);
        tick();
        check("mc_we", we_o, 1);
        check("mc_rd_s", rd_s_o, 3);
        check("mc_rd_v", rd_v_o, 7);
        tick();
        check("mc_done", we_o, 0);

        // mc x0 write is accepted and dropped
        mc_on(0, 9);
        check("x0_ready", mc_ready_o, 1);
        tick();
        mc_off();
        for (int i = 0; i < 3; i++) begin
            check("x0_ready_after", mc_ready_o, 1);
            check("x0_no_write", we_o, 0);
            tick();
        end

        // Fill with continuous pipe traffic
        pipe_on(10, 32'h100);
        mc_on(4, 32'h44);
        tick();
        check("fill_stall_c1", stall_o, 0);
        mc_on(6, 32'h66);
        tick();
        mc_off();
        check("fill_full", mc_ready_o, 0);
        for (int c = 2; c <= 4; c++) begin
            check("fill_stall_low", stall_o, 0);
            check("fill_pipe_wins", rd_s_o, 10);
            tick();
        end
`ifdef WB_STARVE_GUARD_EN
        check("starve_stall", stall_o, 1);
        check("starve_full", mc_ready_o, 0);
        tick();
        check("starve_we", we_o, 1);
        check("starve_rd_s", rd_s_o, 4);
        check("starve_rd_v", rd_v_o, 32'h44);
        check("starve_stall_clr", stall_o, 0);
        check("starve_ready", mc_ready_o, 1);
        tick();
        check("post_starve_pipe", rd_s_o, 10);
        pipe_off();
        tick();
        check("drain2_rd_s", rd_s_o, 6);
        check("drain2_rd_v", rd_v_o, 32'h66);
`else
        check("nostarve_stall", stall_o, 0);
        check("nostarve_full", mc_ready_o, 0);
        tick();
        check("nostarve_pipe", rd_s_o, 10);
        pipe_off();
        tick();
        check("drain1_rd_s", rd_s_o, 4);
        check("drain1_rd_v", rd_v_o, 32'h44);
        tick();
        check("drain2_rd_s", rd_s_o, 6);
        check("drain2_rd_v", rd_v_o, 32'h66);
`endif
        tick();
        check("drained_we", we_o, 0);
        check("drained_ready", mc_ready_o, 1);

        // Push and pop every cycle at occupancy 1: 20 entries = 10 wraps of a 2-deep FIFO
        for (int i = 0; i < 20; i++) begin
            mc_on(5'((i % 31) + 1), 32'h1000 + 32'(i));
            tick();
            check("wrap_ready", mc_ready_o, 1);
            if (i > 0) begin
                check("wrap_we", we_o, 1);
                check("wrap_rd_s", rd_s_o, ((i - 1) % 31) + 1);
                check("wrap_rd_v", rd_v_o, 32'h1000 + 32'(i - 1));
            end
        end
        mc_off();
        tick();
        check("wrap_last_v", rd_v_o, 32'h1000 + 32'd19);
        tick();
        check("wrap_end_we", we_o, 0);

        // Reset with two entries queued behind pipe traffic
        pipe_on(10, 32'h100);
        mc_on(8, 32'h88);
        tick();
        mc_on(9, 32'h99);
        tick();
        mc_off();
        check("prerst_full", mc_ready_o, 0);
        pipe_off();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_we", we_o, 0);
        check("midrst_rd_s", rd_s_o, 0);
        check("midrst_rd_v", rd_v_o, 0);
        check("midrst_ready", mc_ready_o, 1);
        check("midrst_stall", stall_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_write", we_o, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, multi-cycle result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive non-drain cycles before forced drain.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port pipe_valid_i  input  1  in-order pipeline result present this cycle.
REQ-006 SHALL have port pipe_we_i  input  1  pipeline result writes a register.
REQ-007 SHALL have port pipe_rd_s_i  input  RF_IDX_BITS  pipeline destination index.
REQ-008 SHALL have port pipe_rd_v_i  input  XLEN  pipeline result value.
REQ-009 SHALL have port mc_valid_i  input  1  multi-cycle unit result offered.
REQ-010 SHALL have port mc_ready_o  output  1  FIFO can accept; a transfer occurs when valid and ready are both high.
REQ-011 SHALL have port mc_rd_s_i  input  RF_IDX_BITS  multi-cycle destination index.
REQ-012 SHALL have port mc_rd_v_i  input  XLEN  multi-cycle result value.
REQ-013 SHALL have port stall_o  output  1  pipeline must hold its writeback result this cycle.
REQ-014 SHALL have port we_o  output  1  register file write enable, registered.
REQ-015 SHALL have port rd_s_o  output  RF_IDX_BITS  register file write index, registered.
REQ-016 SHALL have port rd_v_o  output  XLEN  register file write value, registered.

Function
REQ-017 SHALL define pipe_req as pipe_valid_i && pipe_we_i && pipe_rd_s_i != 0.
REQ-018 SHALL drive mc_ready_o = !full, from FIFO state only; no combinational path from mc_valid_i or pop.
REQ-019 SHALL accept an mc transfer with mc_rd_s_i == 0 without pushing it (dropped x0 write).
REQ-020 SHALL make a pushed entry eligible for drain from the next cycle; there is no same-cycle bypass.
REQ-021 SHALL select the winner each cycle in this order: forced drain (REQ-026) first, then pipe_req, then FIFO head if non-empty, otherwise none.
REQ-022 SHALL present the winner on we_o/rd_s_o/rd_v_o one cycle later; with no winner, we_o=0 and rd_s_o/rd_v_o hold their previous values.
REQ-023 SHALL pop the FIFO head in the cycle it wins.
REQ-024 SHALL allow push and pop in the same cycle; occupancy is then unchanged, and push when full is impossible per REQ-018.
REQ-025 SHALL wrap read and write pointers modulo DEPTH and keep full/empty correct across wrap-around.
REQ-026 SHALL force a drain when the starvation counter equals STARVE_LIMIT: stall_o=1 combinationally, FIFO head wins, pipe input is ignored and must be re-presented.
REQ-027 SHALL clear the starvation counter on every FIFO pop and while the FIFO is empty; it increments (saturating at STARVE_LIMIT) when non-empty and not popped.
REQ-028 SHALL hold stall_o=0 in every other cycle.

Reset
REQ-029 SHALL, on rst_i, clear we_o, rd_s_o, rd_v_o, stall_o, both FIFO pointers and the starvation counter to 0; mc_ready_o=1 the next cycle.
REQ-030 SHALL discard FIFO contents when reset arrives mid-operation; no write issues in the cycle after reset.

Configuration
REQ-031 SHALL, with WB_STARVE_GUARD_EN defined, implement REQ-026/027 as specified.
REQ-032 SHALL, without WB_STARVE_GUARD_EN, tie stall_o to 0, omit the counter, and give pipe_req strict priority always.

Structure
REQ-033 SHALL take XLEN and RF_IDX_BITS from orion_types, and add WB_FIFO_DEPTH and WB_STARVE_LIMIT defaults and a wb_entry_t struct (rd_s, rd_v) there.
REQ-034 SHALL contain one sub-module, wb_fifo (parameterised depth, push/pop/full/empty).

Verification
REQ-035 SHALL cover: pipe_req rd=5 val=0xA5 with FIFO empty -> next cycle we_o=1, rd_s_o=5, rd_v_o=0xA5.
REQ-036 SHALL cover: mc push rd=3 val=7 with pipe idle -> we_o=1 with rd=3 two cycles after the push edge.
REQ-037 SHALL cover: mc push rd=0 -> mc_ready_o stays 1, occupancy stays 0, no write ever issues.
REQ-038 SHALL cover: fill FIFO (2 pushes) while pipe_req is continuous -> mc_ready_o=0; with the guard enabled, stall_o=1 exactly 4 cycles after the first push becomes eligible, and the head drains that cycle.
REQ-039 SHALL cover: same-cycle push and pop at occupancy 1 -> occupancy stays 1, FIFO order is preserved across 10 wraps.
REQ-040 SHALL cover: rst_i asserted with 2 entries queued -> we_o=0 the following cycle, mc_ready_o=1, queued writes never appear.
